object_rom_arbiter: RTL and testbench

- Shared, parametrised object/sprite ROM that serves N_CH independent read clients through one synchronous ROM port.
- Round-robin arbitration accepts at most one read per cycle, with a grant/response handshake and channel-tagged responses.
- Optional output register trades one cycle of latency for timing.
- Sits between the per-object pixel fetchers of the VGA drawing path and the MIF-initialised object memory; it replaces per-fetcher ROM copies.

---
 rtl/object_mem_pkg.sv | 20 ++
 rtl/object_rom_core.sv | 62 ++++++
 rtl/object_rom_arbiter.sv | 100 ++++++++++
 tb/tb_object_rom_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/object_mem_pkg.sv
// Shared constants and elaboration-time helpers for the object ROM arbiter.
package object_mem_pkg;

  localparam int DEFAULT_N  = 3;
  localparam int DEFAULT_MN = 6;
  localparam DEFAULT_INIT_FILE = "./MIF/object_mem_8_8_3.mif";

  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int v = value - 1; v > 0; v = v >>> 1) width++;
    return width;
  endfunction

  // A single-client build still needs a one-bit tag to keep the port legal.
  function automatic int tag_width(input int n_ch);
    return (n_ch <= 1) ? 1 : clog2(n_ch);
  endfunction

endpackage

// File: rtl/object_rom_core.sv
// Single-port synchronous ROM holding the object/sprite image.
// Address is registered on clk; q_o follows the registered address combinationally.
module object_rom_core
  import object_mem_pkg::*;
#(
  parameter int n  = DEFAULT_N,
  parameter int Mn = DEFAULT_MN,
  parameter INIT_FILE = DEFAULT_INIT_FILE
) (
  input  logic          clk,
  input  logic          addr_en_i,
  input  logic [Mn-1:0] addr_i,
  output logic [n-1:0]  q_o
);

`ifdef OBJECT_ROM_ALTSYNCRAM
  altsyncram #(
    .operation_mode        ("ROM"),
    .intended_device_family("Cyclone V"),
    .lpm_type              ("altsyncram"),
    .widthad_a             (Mn),
    .numwords_a            (1 << Mn),
    .width_a               (n),
    .width_byteena_a       (1),
    .init_file             (INIT_FILE),
    .outdata_reg_a         ("UNREGISTERED"),
    .outdata_aclr_a        ("NONE"),
    .address_aclr_a        ("NONE"),
    .clock_enable_input_a  ("BYPASS"),
    .clock_enable_output_a ("BYPASS")
  ) u_rom (
    .clock0        (clk),
    .address_a     (addr_i),
    .addressstall_a(~addr_en_i),
    .q_a           (q_o)
  );
`else
  // Behavioural image of the object MIF: address bits folded by XOR into n-bit words.
  localparam int CHUNKS = (Mn + n - 1) / n;

  logic [Mn-1:0]         addr_q;
  logic [CHUNKS*n-1:0]   addr_pad;

  if ($bits(INIT_FILE) < 8) begin : g_no_image
    $error("object_rom_core: INIT_FILE must name the object memory image");
  end

  // NOTE: the address register is memory-side state like the array itself, so it takes no reset.
  always_ff @(posedge clk) begin
    if (addr_en_i) addr_q <= addr_i;
  end

  assign addr_pad = (CHUNKS*n)'(addr_q);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    q_o = '0;
    for (int c = 0; c < CHUNKS; c++) q_o = q_o ^ addr_pad[c*n +: n];
  end
`endif

endmodule

// File: rtl/object_rom_arbiter.sv
// Round-robin front end sharing one object ROM among N_CH pixel fetchers.
// One read accepted per cycle; responses are channel-tagged and arrive 1+OUT_REG cycles after grant.
module object_rom_arbiter
  import object_mem_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int n       = DEFAULT_N,
  parameter int Mn      = DEFAULT_MN,
  parameter int OUT_REG = 0,
  parameter INIT_FILE   = DEFAULT_INIT_FILE,
  localparam int CW     = tag_width(N_CH)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [N_CH-1:0]    req,
  input  logic [N_CH*Mn-1:0] addr,
  output logic [N_CH-1:0]    gnt,
  output logic               rvalid,
  output logic [CW-1:0]      rch,
  output logic [n-1:0]       rdata
);

  localparam int L = 1 + OUT_REG;

  logic [CW-1:0]     ptr_q, ptr_d;
  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   req_rot;
  logic              any_gnt;
  logic [CW-1:0]     gnt_idx;
  int                sel_off, sel_ch, nxt_ch;

  logic [Mn-1:0]     rom_addr;
  logic [n-1:0]      rom_q, data_l;

  logic [L-1:0]      vld_q;
  logic [CW-1:0]     tag_q [L];

  // Rotate requests so bit k is channel (ptr+k) mod N_CH; the lowest set bit wins.
  assign req_dbl = {req, req};
  assign req_rot = N_CH'(req_dbl >> ptr_q);

  always_comb begin
    sel_off = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) sel_off = k;
    end
    sel_ch = int'(ptr_q) + sel_off;
    if (sel_ch >= N_CH) sel_ch = sel_ch - N_CH;
    nxt_ch = sel_ch + 1;
    if (nxt_ch >= N_CH) nxt_ch = 0;
    any_gnt = resetn & (|req_rot);
    gnt_idx = any_gnt ? CW'(sel_ch) : '0;
    gnt     = any_gnt ? (N_CH'(1) << gnt_idx) : '0;
    ptr_d   = any_gnt ? CW'(nxt_ch) : ptr_q;
  end

  assign rom_addr = Mn'(addr >> (int'(gnt_idx) * Mn));

  object_rom_core #(
    .n        (n),
    .Mn       (Mn),
    .INIT_FILE(INIT_FILE)
  ) u_core (
    .clk      (clock),
    .addr_en_i(any_gnt),
    .addr_i   (rom_addr),
    .q_o      (rom_q)
  );

  // NOTE: sequential state uses non-blocking assignment so every stage samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ptr_q <= '0;
      vld_q <= '0;
      for (int s = 0; s < L; s++) tag_q[s] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      vld_q[0] <= any_gnt;
      tag_q[0] <= gnt_idx;
      for (int s = 1; s < L; s++) begin
        vld_q[s] <= vld_q[s-1];
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [n-1:0] rdata_q;
    always_ff @(posedge clock) rdata_q <= rom_q;
    assign data_l = rdata_q;
  end else begin : g_no_out_reg
    assign data_l = rom_q;
  end

  // Gating on resetn hides an in-flight response during the reset cycle itself.
  assign rvalid = resetn & vld_q[L-1];
  assign rch    = rvalid ? tag_q[L-1] : '0;
  assign rdata  = rvalid ? data_l : '0;

endmodule

// File: tb/tb_object_rom_arbiter.sv
// Scoreboard bench: drives two arbiters (OUT_REG=0 and OUT_REG=1) with the same stimulus,
// models round-robin grants and the ROM image, and matches tagged responses per cycle.
module tb_object_rom_arbiter;

  localparam int N_CH = 4;
  localparam int NW   = 3;
  localparam int MW   = 6;

  logic                 clock  = 1'b0;
  logic                 resetn = 1'b0;
  logic [N_CH-1:0]      req    = '0;
  logic [N_CH*MW-1:0]   addr   = '0;

  logic [N_CH-1:0] gnt0, gnt1;
  logic            rvalid0, rvalid1;
  logic [1:0]      rch0, rch1;
  logic [NW-1:0]   rdata0, rdata1;

  typedef struct {
    int         due;
    int         ch;
    logic [2:0] data;
  } resp_t;

  resp_t sb0[$];
  resp_t sb1[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ptr_m    = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  object_rom_arbiter #(.N_CH(N_CH), .n(NW), .Mn(MW), .OUT_REG(0)) dut0 (
    .clock(clock), .resetn(resetn), .req(req), .addr(addr),
    .gnt(gnt0), .rvalid(rvalid0), .rch(rch0), .rdata(rdata0)
  );

  object_rom_arbiter #(.N_CH(N_CH), .n(NW), .Mn(MW), .OUT_REG(1)) dut1 (
    .clock(clock), .resetn(resetn), .req(req), .addr(addr),
    .gnt(gnt1), .rvalid(rvalid1), .rch(rch1), .rdata(rdata1)
  );

  function automatic logic [2:0] rom_model(input logic [5:0] a);
    return a[2:0] ^ a[5:3];
  endfunction

  // Response monitor, sampled mid-cycle on the falling edge.
  always @(negedge clock) begin
    resp_t e;
    n_checks++;
    if (sb0.size() > 0 && sb0[0].due == cyc) begin
      e = sb0.pop_front();
      if (rvalid0 !== 1'b1 || rch0 !== 2'(e.ch) || rdata0 !== e.data) begin
        n_fail++;
        $display("FAIL resp_out0 cyc=%0d: got v=%b ch=%0d d=%0d, want v=1 ch=%0d d=%0d",
                 cyc, rvalid0, rch0, rdata0, e.ch, e.data);
      end
    end else if (rvalid0 !== 1'b0 || rdata0 !== 3'd0) begin
      n_fail++;
      $display("FAIL idle_out0 cyc=%0d: got v=%b d=%0d, want v=0 d=0", cyc, rvalid0, rdata0);
    end
    n_checks++;
    if (sb1.size() > 0 && sb1[0].due == cyc) begin
      e = sb1.pop_front();
      if (rvalid1 !== 1'b1 || rch1 !== 2'(e.ch) || rdata1 !== e.data) begin
        n_fail++;
        $display("FAIL resp_out1 cyc=%0d: got v=%b ch=%0d d=%0d, want v=1 ch=%0d d=%0d",
                 cyc, rvalid1, rch1, rdata1, e.ch, e.data);
      end
    end else if (rvalid1 !== 1'b0 || rdata1 !== 3'd0) begin
      n_fail++;
      $display("FAIL idle_out1 cyc=%0d: got v=%b d=%0d, want v=0 d=0", cyc, rvalid1, rdata1);
    end
    if (!resetn) begin
      n_checks++;
      if (rch0 !== 2'd0 || rch1 !== 2'd0) begin
        n_fail++;
        $display("FAIL rch_in_reset cyc=%0d: got %0d/%0d, want 0/0", cyc, rch0, rch1);
      end
    end
  end

  // One clock cycle: drive inputs, check the combinational grant, queue expected responses.
  task automatic step(input logic rst_n, input logic [3:0] r, input logic [23:0] a);
    logic [3:0] exp_g;
    logic [5:0] ga;
    int         g;
    resetn = rst_n;
    req    = r;
    addr   = a;
    #1;
    exp_g = '0;
    g     = -1;
    if (rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        int c;
        c = (ptr_m + k) % N_CH;
        if (g < 0 && r[c]) g = c;
      end
    end
    if (g >= 0) exp_g[g] = 1'b1;
    n_checks++;
    if (gnt0 !== exp_g || gnt1 !== exp_g) begin
      n_fail++;
      $display("FAIL gnt cyc=%0d: got %b/%b, want %b", cyc, gnt0, gnt1, exp_g);
    end
    if (!rst_n) begin
      sb0.delete();
      sb1.delete();
      ptr_m = 0;
    end else if (g >= 0) begin
      ga = a[g*MW +: MW];
      sb0.push_back(resp_t'{cyc + 1, g, rom_model(ga)});
      sb1.push_back(resp_t'{cyc + 2, g, rom_model(ga)});
      ptr_m = (g + 1) % N_CH;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 4'b0000, 24'h0);
  endtask

  function automatic logic [23:0] pack(input logic [5:0] a3, input logic [5:0] a2,
                                       input logic [5:0] a1, input logic [5:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, pack(6'o01, 6'o02, 6'o03, 6'o04));
    step(1'b1, 4'b1111, pack(6'o01, 6'o02, 6'o03, 6'o04));
    idle(3);
  endtask

  task automatic test_single_read();
    step(1'b1, 4'b0100, pack(6'o00, 6'o25, 6'o00, 6'o00));
    idle(2);
    step(1'b1, 4'b0001, pack(6'o00, 6'o00, 6'o00, 6'o00));
    step(1'b1, 4'b1000, pack(6'o70, 6'o00, 6'o00, 6'o00));
    idle(3);
  endtask

  task automatic test_round_robin();
    step(1'b1, 4'b1000, pack(6'o12, 6'o00, 6'o00, 6'o00));
    for (int i = 0; i < 8; i++)
      step(1'b1, 4'b1111, pack(6'(i + 40), 6'(i + 20), 6'(i + 9), 6'(i)));
    idle(3);
  endtask

  task automatic test_wrap_skip();
    step(1'b1, 4'b1000, pack(6'o77, 6'o00, 6'o00, 6'o00));
    step(1'b1, 4'b0010, pack(6'o00, 6'o00, 6'o31, 6'o00));
    step(1'b1, 4'b0011, pack(6'o00, 6'o00, 6'o31, 6'o46));
    idle(3);
  endtask

  task automatic test_out_reg();
    step(1'b1, 4'b0010, pack(6'o00, 6'o00, 6'h3F, 6'o00));
    idle(4);
  endtask

  task automatic test_dropped_req();
    step(1'b1, 4'b1000, pack(6'o05, 6'o00, 6'o00, 6'o00));
    step(1'b1, 4'b1001, pack(6'o05, 6'o00, 6'o00, 6'o13));
    step(1'b1, 4'b0000, pack(6'o05, 6'o00, 6'o00, 6'o13));
    idle(3);
  endtask

  task automatic test_reset_midflight();
    step(1'b1, 4'b0001, pack(6'o00, 6'o00, 6'o00, 6'o34));
    step(1'b0, 4'b0000, 24'h0);
    idle(4);
    step(1'b1, 4'b0010, pack(6'o00, 6'o00, 6'o52, 6'o00));
    idle(2);
    step(1'b0, 4'b1010, pack(6'o00, 6'o00, 6'o66, 6'o00));
    step(1'b0, 4'b1010, pack(6'o00, 6'o00, 6'o66, 6'o00));
    step(1'b1, 4'b1010, pack(6'o21, 6'o00, 6'o66, 6'o00));
    idle(3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      step(1'b1, 4'($urandom_range(0, 15)), 24'($urandom));
    idle(4);
  endtask

  initial begin
    @(posedge clock);
    #1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_wrap_skip();
    test_out_reg();
    test_dropped_req();
    test_reset_midflight();
    test_back_to_back();
    n_checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d responses outstanding, want 0/0", sb0.size(), sb1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
